// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between the CPU and a host
// debug/loader port. The CPU owns the RAM by default. A host access
// freezes the CPU for two cycles: one slot for the host access and one
// slot to re-issue the CPU's pending read address. After each slot the
// host must wait a minimum number of running CPU cycles before the next one.

module mem_port_arbiter #(
  parameter int AW  = 12,
  parameter int DW  = 32,
  parameter int GAP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_run,
  output logic          cpu_hold,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] RESTORE = 2'd2;

  localparam logic [3:0] GAP_LOAD = 4'(GAP);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [3:0] gap_cnt;

  // Next-state decode: a host slot is granted only once the gap counter has drained
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = (host_req && (gap_cnt == 4'd0)) ? HOLD : IDLE;
      HOLD:    state_next = RESTORE;
      RESTORE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; a reset mid-access abandons the host access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Gap counter: reloaded after each slot, counts down only while the CPU runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                gap_cnt <= 4'd0;
    else if (!cpu_run)                         gap_cnt <= 4'd0;
    else if (state == RESTORE)                 gap_cnt <= GAP_LOAD;
    else if (state == IDLE && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
  end

  // Host completion: ack pulse and read data captured at the RESTORE exit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= (state == RESTORE);
      if (state == RESTORE && !host_we) host_rdata <= mem_dout;
    end
  end

  // Freeze is a pure state decode so it cannot glitch
  assign cpu_hold = (state == HOLD) || (state == RESTORE);

  // RAM port steering: CPU by default, host in HOLD, CPU read replay in RESTORE
  always_comb begin
    mem_we   = cpu_we;
    mem_addr = cpu_addr;
    mem_din  = cpu_din;
    case (state)
      HOLD: begin
        mem_we   = host_we;
        mem_addr = host_addr;
        mem_din  = host_wdata;
      end
      RESTORE: begin
        mem_we   = 1'b0;
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
      end
      default: begin
        mem_we   = cpu_we;
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
      end
    endcase
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares the single-port synchronous 4Kx32 program/data RAM between the CPU core and a host debug/loader port. The CPU owns the RAM by default. A host access steals one RAM slot: the CPU is frozen with `cpu_hold`, and the CPU's pending read address is re-issued before it is released. The block sits between the CPU's memory-side signals and the RAM macro.

## Interface

Parameters:
- `AW`, 12, RAM address width.
- `DW`, 32, RAM data width.
- `GAP`, 2, minimum number of unheld CPU cycles between two host slots (1..15).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cpu_we` input 1: CPU write strobe.
- `cpu_addr` input AW: CPU RAM address, already next-cycle-selected by the CPU.
- `cpu_din` input DW: CPU write data.
- `cpu_run` input 1: CPU S flag; 0 means halted, which waives `GAP`.
- `cpu_hold` output 1: freeze request; the top level ORs it into the CPU's stop/enable.
- `host_req` input 1: host access request, level.
- `host_we` input 1: host write (1) or read (0).
- `host_addr` input AW: host address.
- `host_wdata` input DW: host write data.
- `host_ack` output 1: one-cycle completion pulse.
- `host_rdata` output DW: registered host read data.
- `mem_we` output 1: RAM write enable.
- `mem_addr` output AW: RAM address.
- `mem_din` output DW: RAM write data.
- `mem_dout` input DW: RAM read data (synchronous, 1-cycle).

## Operation

- FSM states: IDLE, HOLD, RESTORE.
- **IDLE:**
  - `mem_we=cpu_we`, `mem_addr=cpu_addr`, `mem_din=cpu_din`, `cpu_hold=0`.
  - Go to HOLD when `host_req=1` and `gap_cnt==0`.
- **HOLD:**
  - `cpu_hold=1`.
  - `mem_we=host_we`, `mem_addr=host_addr`, `mem_din=host_wdata`, all combinational from the host pins.
  - Always goes to RESTORE next.
- **RESTORE:**
  - `cpu_hold=1`, `mem_we=0`, `mem_addr=cpu_addr`. This re-launches the frozen CPU read so that `mem_dout` is correct when the CPU resumes.
  - At the exit edge: `host_rdata<=mem_dout` on a read (unchanged on a write), `host_ack<=1`, `gap_cnt<=GAP`.
  - Always goes to IDLE next.
- **`host_ack`:** registered. High exactly in the first IDLE cycle after RESTORE, low otherwise.
- **`gap_cnt`:**
  - 4-bit. Decrements by 1 per IDLE cycle while `cpu_run=1` and it is nonzero.
  - Forced to 0 in any cycle with `cpu_run=0`, so back-to-back host slots are allowed while the CPU is halted.
- **Host protocol:**
  - `host_req`, `host_we`, `host_addr` and `host_wdata` must be held stable from request until `host_ack`.
  - The host must drop `host_req` in the ack cycle, or it raises a new request.
- **CPU write during grant:**
  - A CPU write presented in the IDLE grant cycle is performed in that cycle.
  - A CPU write presented while `cpu_hold=1` is deferred: the CPU is frozen, so it reappears in the next IDLE cycle.
  - No CPU write is ever lost or duplicated.
- **Reset:**
  - Outputs: FSM=IDLE, `cpu_hold=0`, `host_ack=0`, `host_rdata=0`, `gap_cnt=0`.
  - `mem_*` follow the CPU pins.
  - Reset during HOLD or RESTORE abandons the host access with no ack. A host write in HOLD may or may not have been committed to RAM.

## Timing

- Grant latency: a host request sampled in IDLE with `gap_cnt==0` gives HOLD in the next cycle.
- Access duration: request to ack is 3 cycles minimum (IDLE-sample, HOLD, RESTORE, ack in the following IDLE).
- CPU cost per host access: exactly 2 held cycles.
- Host RAM access: the write commits at the HOLD exit edge. Read data is on `mem_dout` during RESTORE and is registered into `host_rdata` at the RESTORE exit edge.
- Maximum host bandwidth with the CPU running: one access per 2+1+`GAP` cycles (5 cycles with `GAP=2`). With the CPU halted: one per 3 cycles.
- `cpu_hold` is a pure decode of the FSM state, glitch-free with respect to `clk`.

## Test plan

- **Host read, CPU running:** preload `mem[0x123]=0xDEADBEEF`; assert `host_req`, `host_we=0`, `host_addr=0x123`.
  - `cpu_hold` is high for exactly 2 cycles.
  - `host_ack` pulses in the 4th cycle with `host_rdata=0xDEADBEEF`.
  - CPU program results are identical to a run with no host traffic.
- **Host write:** `host_addr=0x0FF`, `host_wdata=0x00000042`, then a host read of `0x0FF`.
  - The read returns `0x42`.
  - A CPU LDA from `0x0FF` afterwards loads `0x42`.
- **Collision with CPU STA:** the CPU stores `0x5555` to `0x200` in the same cycle the host request is granted, and the host writes `0xAAAA` to `0x201`.
  - Result: `mem[0x200]=0x5555` and `mem[0x201]=0xAAAA`.
- **Gap enforcement:** hold `host_req` high continuously with `cpu_run=1` and `GAP=2`.
  - Successive `host_ack` pulses are exactly 5 cycles apart.
  - After `cpu_run` goes to 0, they are 3 cycles apart.
- **Async reset mid-access:** pull `rst_n` low during HOLD.
  - `cpu_hold`, `host_ack` and `host_rdata` are 0 immediately, without waiting for a clock edge.
  - The FSM is in IDLE after release, and no ack pulse occurs.
